i2c_slave_rx_seq: RTL

I2C_SLAVE_RX_SEQ -- requirements
Module: i2c_slave_rx_seq

---
 rtl/i2c_slave_rx_seq.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_rx_seq.sv
// I2C slave receive sequencer: drives an external bit reader and ACK driver,
// matches the address byte and hands received data bytes to a ready/valid sink.
module i2c_slave_rx_seq #(
  parameter int OWN_ADDR_W = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [OWN_ADDR_W-1:0] own_addr,
  output logic                  rd_en,
  output logic                  is_byte,
  input  logic                  rd_ld,
  input  logic                  rd_bit,
  input  logic                  rd_finish,
  input  logic                  rd_err,
  input  logic                  get_start,
  input  logic                  get_stop,
  output logic                  ack_en,
  output logic                  ack_bit,
  input  logic                  ack_done,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  busy,
  output logic                  tx_req,
  output logic                  err,
  output logic                  ovf,
  output logic [7:0]            byte_cnt
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_CHK, ACK, DATA, DATA_CHK, HANDOFF, WAIT_STOP
  } state_t;

  // Remembers why the ACK state was entered, so ack_done knows where to go.
  typedef enum logic [1:0] {
    ACK_ADDR_W, ACK_ADDR_R, ACK_DATA, ACK_NACK
  } ack_sel_t;

  state_t     state_reg, state_next;
  ack_sel_t   ack_sel_reg, ack_sel_next;
  logic [7:0] shift_reg, shift_next;
  logic       rd_en_reg, rd_en_next;
  logic       is_byte_reg, is_byte_next;
  logic       ack_en_reg, ack_en_next;
  logic       ack_bit_reg, ack_bit_next;
  logic [7:0] rx_data_reg, rx_data_next;
  logic       rx_valid_reg, rx_valid_next;
  logic       tx_req_reg, tx_req_next;
  logic       err_reg, err_next;
  logic       ovf_reg, ovf_next;
  logic [7:0] byte_cnt_reg, byte_cnt_next;
  logic       busy_reg, busy_next;

  logic [6:0] addr_cmp;
  logic       hold_free;

  assign addr_cmp  = 7'(own_addr);
  // The holding register can take a byte if empty or being drained this cycle.
  assign hold_free = !rx_valid_reg || rx_ready;

  always_comb begin
    state_next    = state_reg;
    ack_sel_next  = ack_sel_reg;
    shift_next    = shift_reg;
    rd_en_next    = 1'b0;
    ack_en_next   = ack_en_reg;
    ack_bit_next  = ack_bit_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = rx_valid_reg && !rx_ready;
    tx_req_next   = 1'b0;
    err_next      = 1'b0;
    ovf_next      = ovf_reg;
    byte_cnt_next = byte_cnt_reg;

    if ((state_reg == ADDR || state_reg == DATA) && rd_ld) begin
      shift_next = {shift_reg[6:0], rd_bit};
    end

    if (get_stop) begin
      state_next  = IDLE;
      ack_en_next = 1'b0;
    end else if (get_start) begin
      state_next  = ADDR;
      ack_en_next = 1'b0;
      shift_next  = 8'h00;
      if (state_reg == IDLE) begin
        byte_cnt_next = 8'h00;
        ovf_next      = 1'b0;
      end
    end else begin
      unique case (state_reg)
        IDLE: ;
        ADDR, DATA: begin
          if (rd_err) begin
            err_next   = 1'b1;
            shift_next = 8'h00;
            state_next = WAIT_STOP;
          end else if (rd_finish) begin
            state_next = (state_reg == ADDR) ? ADDR_CHK : DATA_CHK;
          end else begin
            // rd_en rises one cycle after entry, so it is always low between bytes.
            rd_en_next = 1'b1;
          end
        end
        ADDR_CHK: begin
          if (shift_reg[7:1] == addr_cmp) begin
            ack_en_next  = 1'b1;
            ack_bit_next = 1'b0;
            ack_sel_next = shift_reg[0] ? ACK_ADDR_R : ACK_ADDR_W;
            state_next   = ACK;
          end else begin
            state_next = WAIT_STOP;
          end
        end
        ACK: begin
          if (ack_done) begin
            ack_en_next = 1'b0;
            unique case (ack_sel_reg)
              ACK_ADDR_W, ACK_DATA: begin
                shift_next = 8'h00;
                state_next = DATA;
              end
              ACK_ADDR_R: begin
                tx_req_next = 1'b1;
                state_next  = HANDOFF;
              end
              ACK_NACK: state_next = WAIT_STOP;
              default:  state_next = WAIT_STOP;
            endcase
          end
        end
        DATA_CHK: begin
          ack_en_next = 1'b1;
          state_next  = ACK;
          if (hold_free) begin
            rx_data_next  = shift_reg;
            rx_valid_next = 1'b1;
            if (byte_cnt_reg != 8'hFF) begin
              byte_cnt_next = byte_cnt_reg + 8'd1;
            end
            ack_bit_next = 1'b0;
            ack_sel_next = ACK_DATA;
          end else begin
            ack_bit_next = 1'b1;
            ovf_next     = 1'b1;
            ack_sel_next = ACK_NACK;
          end
        end
        HANDOFF, WAIT_STOP: ;
        default: state_next = IDLE;
      endcase
    end

    busy_next    = (state_next != IDLE);
    is_byte_next = (state_next == ADDR) || (state_next == DATA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ack_sel_reg  <= ACK_ADDR_W;
      shift_reg    <= 8'h00;
      rd_en_reg    <= 1'b0;
      is_byte_reg  <= 1'b0;
      ack_en_reg   <= 1'b0;
      ack_bit_reg  <= 1'b0;
      rx_data_reg  <= 8'h00;
      rx_valid_reg <= 1'b0;
      tx_req_reg   <= 1'b0;
      err_reg      <= 1'b0;
      ovf_reg      <= 1'b0;
      byte_cnt_reg <= 8'h00;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ack_sel_reg  <= ack_sel_next;
      shift_reg    <= shift_next;
      rd_en_reg    <= rd_en_next;
      is_byte_reg  <= is_byte_next;
      ack_en_reg   <= ack_en_next;
      ack_bit_reg  <= ack_bit_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      tx_req_reg   <= tx_req_next;
      err_reg      <= err_next;
      ovf_reg      <= ovf_next;
      byte_cnt_reg <= byte_cnt_next;
      busy_reg     <= busy_next;
    end
  end

  assign rd_en    = rd_en_reg;
  assign is_byte  = is_byte_reg;
  assign ack_en   = ack_en_reg;
  assign ack_bit  = ack_bit_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign tx_req   = tx_req_reg;
  assign err      = err_reg;
  assign ovf      = ovf_reg;
  assign byte_cnt = byte_cnt_reg;
  assign busy     = busy_reg;

endmodule
